// File: rtl/definitions_pkg.sv
`default_nettype none
// ============================================================================
// Module      : definitions_pkg
// Description : Constants and FSM state type shared by the UART TX/RX pair.
// Revision    : 1.0 - initial release
// ============================================================================
package definitions_pkg;

    localparam int OVERSAMPLE_RATE   = 16;
    localparam int DEFAULT_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_oversampled_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_oversampled_if
// Description : Serial-side inputs and parallel-side results of the UART RX.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_oversampled_if
    import definitions_pkg::*;
#(
    parameter int DATA_BITS = DEFAULT_DATA_BITS
);
    logic                 s_tick;
    logic                 rx_in;
    logic [DATA_BITS-1:0] rx_out;
    logic                 busy;
    logic                 done;
    logic                 err;

    modport master (output s_tick, rx_in, input  rx_out, busy, done, err);
    modport slave  (input  s_tick, rx_in, output rx_out, busy, done, err);
endinterface
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sync
// Description : 2-flop synchronizer with falling-edge detect; idles high.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync (
    input  wire logic clk,
    input  wire logic rstN,
    input  wire logic async_in,
    output logic      sync_out,
    output logic      fall
);
    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= async_in;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign sync_out = r_sync;
    assign fall     = r_prev & ~r_sync;
endmodule
`default_nettype wire

// File: rtl/uart_rx_oversampled.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_oversampled
// Description : Oversampling 8N1 UART receiver with mid-bit sampling.
//               UART_RX_MAJORITY_EN selects 2-of-3 tick-sample voting.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_oversampled
    import definitions_pkg::*;
#(
    parameter int DATA_BITS = DEFAULT_DATA_BITS
) (
    input  wire logic            clk,
    input  wire logic            rstN,
    uart_rx_oversampled_if.slave bus
);
    localparam int S_WIDTH = $clog2(OVERSAMPLE_RATE);
    localparam int N_WIDTH = $clog2(DATA_BITS);
    localparam logic [S_WIDTH-1:0] S_HALF = S_WIDTH'(OVERSAMPLE_RATE / 2 - 1);
    localparam logic [S_WIDTH-1:0] S_LAST = S_WIDTH'(OVERSAMPLE_RATE - 1);
    localparam logic [N_WIDTH-1:0] N_LAST = N_WIDTH'(DATA_BITS - 1);

    logic                 rx_s;
    logic                 w_fall;
    logic                 w_sample;
    uart_state_t          r_state,  w_state_next;
    logic [S_WIDTH-1:0]   s_reg,    w_s_next;
    logic [N_WIDTH-1:0]   n_reg,    w_n_next;
    logic [DATA_BITS-1:0] shreg,    w_shreg_next;
    logic [DATA_BITS-1:0] r_rx_out, w_rx_out_next;
    logic                 r_busy,   w_busy_next;
    logic                 r_done,   w_done_next;
    logic                 r_err,    w_err_next;
`ifdef UART_RX_MAJORITY_EN
    logic [2:0]           r_maj,    w_maj_next;
`endif

    uart_rx_sync u_sync (
        .clk      (clk),
        .rstN     (rstN),
        .async_in (bus.rx_in),
        .sync_out (rx_s),
        .fall     (w_fall)
    );

    always_comb begin
        w_state_next  = r_state;
        w_s_next      = s_reg;
        w_n_next      = n_reg;
        w_shreg_next  = shreg;
        w_rx_out_next = r_rx_out;
        w_done_next   = 1'b0;
        w_err_next    = 1'b0;
`ifdef UART_RX_MAJORITY_EN
        // Vote over the three most recent tick samples held in the history.
        w_maj_next = bus.s_tick ? {r_maj[1:0], rx_s} : r_maj;
        w_sample   = (r_maj[0] & r_maj[1]) | (r_maj[0] & r_maj[2]) | (r_maj[1] & r_maj[2]);
`else
        w_sample   = rx_s;
`endif

        case (r_state)
            IDLE: begin
                if (w_fall) begin
                    w_state_next = START;
                    w_s_next     = '0;
                end
            end
            START: begin
                if (bus.s_tick) begin
                    if (s_reg == S_HALF) begin
                        w_s_next     = '0;
                        w_n_next     = '0;
                        w_state_next = w_sample ? IDLE : DATA;
                    end else begin
                        w_s_next = s_reg + S_WIDTH'(1);
                    end
                end
            end
            DATA: begin
                if (bus.s_tick) begin
                    if (s_reg == S_LAST) begin
                        w_shreg_next = {w_sample, shreg[DATA_BITS-1:1]};
                        w_s_next     = '0;
                        if (n_reg == N_LAST) begin
                            w_state_next = STOP;
                        end else begin
                            w_n_next = n_reg + N_WIDTH'(1);
                        end
                    end else begin
                        w_s_next = s_reg + S_WIDTH'(1);
                    end
                end
            end
            STOP: begin
                if (bus.s_tick) begin
                    // Decided half a bit early so a back-to-back start edge is seen in IDLE.
                    if (s_reg == S_LAST) begin
                        w_state_next = IDLE;
                        w_s_next     = '0;
                        if (w_sample) begin
                            w_rx_out_next = shreg;
                            w_done_next   = 1'b1;
                        end else begin
                            w_err_next    = 1'b1;
                        end
                    end else begin
                        w_s_next = s_reg + S_WIDTH'(1);
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase

        w_busy_next = (w_state_next != IDLE);
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state  <= IDLE;
            s_reg    <= '0;
            n_reg    <= '0;
            shreg    <= '0;
            r_rx_out <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
            r_maj    <= 3'b111;
`endif
        end else begin
            r_state  <= w_state_next;
            s_reg    <= w_s_next;
            n_reg    <= w_n_next;
            shreg    <= w_shreg_next;
            r_rx_out <= w_rx_out_next;
            r_busy   <= w_busy_next;
            r_done   <= w_done_next;
            r_err    <= w_err_next;
`ifdef UART_RX_MAJORITY_EN
            r_maj    <= w_maj_next;
`endif
        end
    end

    assign bus.rx_out = r_rx_out;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.err    = r_err;
endmodule
`default_nettype wire
